// File: rtl/v_pkg.sv
// Shared types for the query pipe: key/volume/level widths, list depth,
// query opcodes, query FSM states and the registered response bundle.
package v_pkg;

    localparam int ENTRIES_N = 8;
    localparam int KEY_W     = 16;
    localparam int VOL_W     = 16;
    // Level must also hold a count of ENTRIES_N, hence the +1.
    localparam int LEVEL_W   = $clog2(ENTRIES_N + 1);

    typedef logic [KEY_W-1:0]   key_t;
    typedef logic [VOL_W-1:0]   volume_t;
    typedef logic [LEVEL_W-1:0] level_t;

    typedef enum logic [1:0] {
        QRY_KEY   = 2'd0,
        QRY_LEVEL = 2'd1,
        QRY_DUMP  = 2'd2
    } qry_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RSP  = 2'd1,
        DUMP = 2'd2
    } qry_state_t;

    typedef struct packed {
        logic    hit;
        key_t    key;
        volume_t volume;
        level_t  level;
        logic    last;
    } rsp_t;

endpackage

// File: rtl/v_query_mux.sv
// Combinational level-indexed selector over the current list state.
// Ports: i_sel level index; i_vld/i_keys/i_volumes list state;
// o_vld/o_key/o_volume selected entry (all zero when i_sel is out of range).
module v_query_mux
    import v_pkg::*;
#(
    parameter int ENTRIES_N = v_pkg::ENTRIES_N
) (
    input  level_t                  i_sel,
    input  logic [ENTRIES_N-1:0]    i_vld,
    input  key_t [ENTRIES_N-1:0]    i_keys,
    input  volume_t [ENTRIES_N-1:0] i_volumes,
    output logic                    o_vld,
    output key_t                    o_key,
    output volume_t                 o_volume
);

    always_comb begin
        o_vld    = 1'b0;
        o_key    = '0;
        o_volume = '0;
        for (int i = 0; i < ENTRIES_N; i++) begin
            if (i_sel == level_t'(i)) begin
                o_vld    = i_vld[i];
                o_key    = i_keys[i];
                o_volume = i_volumes[i];
            end
        end
    end

endmodule

// File: rtl/v_pipe_query.sv
// Query front-end for the sorted list: key lookup, level lookup and a
// multi-beat dump that stalls the update pipe while it streams.
// Ports: clk/arst; i_qry_* request with o_qry_rdy; i_stcur_* list state;
// o_upd_stall hold request to the update pipe; o_rsp_* response with i_rsp_rdy.
module v_pipe_query
    import v_pkg::*;
#(
    parameter int ENTRIES_N = v_pkg::ENTRIES_N
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    i_qry_vld,
    input  qry_op_t                 i_qry_op,
    input  key_t                    i_qry_key,
    input  level_t                  i_qry_level,
    output logic                    o_qry_rdy,
    input  logic [ENTRIES_N-1:0]    i_stcur_vld_r,
    input  key_t [ENTRIES_N-1:0]    i_stcur_keys_r,
    input  volume_t [ENTRIES_N-1:0] i_stcur_volumes_r,
    input  level_t                  i_stcur_count_r,
    output logic                    o_upd_stall,
    output logic                    o_rsp_vld,
    input  logic                    i_rsp_rdy,
    output logic                    o_rsp_hit,
    output key_t                    o_rsp_key,
    output volume_t                 o_rsp_volume,
    output level_t                  o_rsp_level,
    output logic                    o_rsp_last
);

    localparam level_t MAX_CNT = level_t'(ENTRIES_N);

    qry_state_t r_state;
    rsp_t       r_rsp;
    logic       r_rsp_vld;
    logic       r_upd_stall;
    level_t     r_dump_idx;
    level_t     r_dump_cnt;

    logic       w_acc;
    level_t     w_cnt;
    level_t     w_nxt_idx;
    level_t     w_sel;
    logic       w_mux_vld;
    key_t       w_mux_key;
    volume_t    w_mux_vol;
    logic       w_km_hit;
    volume_t    w_km_vol;
    level_t     w_km_lvl;
    rsp_t       w_acc_rsp;
    rsp_t       w_dump_rsp;

    assign o_qry_rdy = (r_state == IDLE) |
                       ((r_state == RSP) & i_rsp_rdy);
    assign w_acc     = i_qry_vld & o_qry_rdy;

    // Clamp so the dump index can never walk past the last entry.
    assign w_cnt     = (i_stcur_count_r > MAX_CNT) ?
                       MAX_CNT : i_stcur_count_r;
    assign w_nxt_idx = r_dump_idx + level_t'(1);

    // In DUMP the mux prefetches the next beat; otherwise it
    // serves QRY_LEVEL, and level 0 as the first dump beat.
    always_comb begin
        w_sel = '0;
        if (r_state == DUMP) begin
            w_sel = w_nxt_idx;
        end else if (i_qry_op == QRY_LEVEL) begin
            w_sel = i_qry_level;
        end
    end

    v_query_mux #(
        .ENTRIES_N (ENTRIES_N)
    ) u_mux (
        .i_sel     (w_sel),
        .i_vld     (i_stcur_vld_r),
        .i_keys    (i_stcur_keys_r),
        .i_volumes (i_stcur_volumes_r),
        .o_vld     (w_mux_vld),
        .o_key     (w_mux_key),
        .o_volume  (w_mux_vol)
    );

    // Keys are unique, so at most one valid entry matches.
    always_comb begin
        w_km_hit = 1'b0;
        w_km_vol = '0;
        w_km_lvl = '0;
        for (int i = 0; i < ENTRIES_N; i++) begin
            if (i_stcur_vld_r[i] &&
                (i_stcur_keys_r[i] == i_qry_key)) begin
                w_km_hit = 1'b1;
                w_km_vol = i_stcur_volumes_r[i];
                w_km_lvl = level_t'(i);
            end
        end
    end

    always_comb begin
        w_acc_rsp      = '0;
        w_acc_rsp.last = 1'b1;
        case (i_qry_op)
            QRY_KEY: begin
                w_acc_rsp.hit    = w_km_hit;
                w_acc_rsp.key    = i_qry_key;
                w_acc_rsp.volume = w_km_vol;
                w_acc_rsp.level  = w_km_lvl;
            end
            QRY_LEVEL: begin
                w_acc_rsp.level = i_qry_level;
                if (i_qry_level < w_cnt) begin
                    w_acc_rsp.hit    = w_mux_vld;
                    w_acc_rsp.key    = w_mux_key;
                    w_acc_rsp.volume = w_mux_vol;
                end
            end
            QRY_DUMP: begin
                if (w_cnt != '0) begin
                    w_acc_rsp.hit    = 1'b1;
                    w_acc_rsp.key    = w_mux_key;
                    w_acc_rsp.volume = w_mux_vol;
                    w_acc_rsp.last   = (w_cnt == level_t'(1));
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_dump_rsp        = '0;
        w_dump_rsp.hit    = 1'b1;
        w_dump_rsp.key    = w_mux_key;
        w_dump_rsp.volume = w_mux_vol;
        w_dump_rsp.level  = w_nxt_idx;
        w_dump_rsp.last   =
            ((w_nxt_idx + level_t'(1)) == r_dump_cnt);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state     <= IDLE;
            r_rsp       <= '0;
            r_rsp_vld   <= 1'b0;
            r_upd_stall <= 1'b0;
            r_dump_idx  <= '0;
            r_dump_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE, RSP: begin
                    if (w_acc) begin
                        r_rsp     <= w_acc_rsp;
                        r_rsp_vld <= 1'b1;
                        if ((i_qry_op == QRY_DUMP) &&
                            (w_cnt != '0)) begin
                            r_state     <= DUMP;
                            r_upd_stall <= 1'b1;
                            r_dump_idx  <= '0;
                            r_dump_cnt  <= w_cnt;
                        end else begin
                            r_state <= RSP;
                        end
                    end else if ((r_state == RSP) &&
                                 i_rsp_rdy) begin
                        r_state   <= IDLE;
                        r_rsp_vld <= 1'b0;
                    end
                end
                DUMP: begin
                    if (i_rsp_rdy) begin
                        if (r_rsp.last) begin
                            r_state     <= IDLE;
                            r_rsp_vld   <= 1'b0;
                            r_upd_stall <= 1'b0;
                        end else begin
                            r_rsp      <= w_dump_rsp;
                            r_dump_idx <= w_nxt_idx;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_rsp_vld <= 1'b0;
                end
            endcase
        end
    end

    assign o_upd_stall  = r_upd_stall;
    assign o_rsp_vld    = r_rsp_vld;
    assign o_rsp_hit    = r_rsp.hit;
    assign o_rsp_key    = r_rsp.key;
    assign o_rsp_volume = r_rsp.volume;
    assign o_rsp_level  = r_rsp.level;
    assign o_rsp_last   = r_rsp.last;

endmodule

// File: tb/tb_v_pipe_query.sv
// Self-checking bench for v_pipe_query: queue-based response model,
// per-cycle compare process, directed literal checks and random traffic.
module tb_v_pipe_query;
    import v_pkg::*;

    localparam int N = v_pkg::ENTRIES_N;

    logic    clk = 1'b0;
    logic    arst;
    logic    i_qry_vld = 1'b0;
    qry_op_t i_qry_op = QRY_KEY;
    key_t    i_qry_key = '0;
    level_t  i_qry_level = '0;
    logic    o_qry_rdy;
    logic [N-1:0]    vld_vec;
    key_t [N-1:0]    keys_p;
    volume_t [N-1:0] vols_p;
    level_t  cnt_p;
    logic    o_upd_stall;
    logic    o_rsp_vld;
    logic    i_rsp_rdy = 1'b0;
    logic    o_rsp_hit;
    key_t    o_rsp_key;
    volume_t o_rsp_volume;
    level_t  o_rsp_level;
    logic    o_rsp_last;

    always #5 clk = ~clk;

    v_pipe_query #(.ENTRIES_N(N)) dut (
        .clk               (clk),
        .arst              (arst),
        .i_qry_vld         (i_qry_vld),
        .i_qry_op          (i_qry_op),
        .i_qry_key         (i_qry_key),
        .i_qry_level       (i_qry_level),
        .o_qry_rdy         (o_qry_rdy),
        .i_stcur_vld_r     (vld_vec),
        .i_stcur_keys_r    (keys_p),
        .i_stcur_volumes_r (vols_p),
        .i_stcur_count_r   (cnt_p),
        .o_upd_stall       (o_upd_stall),
        .o_rsp_vld         (o_rsp_vld),
        .i_rsp_rdy         (i_rsp_rdy),
        .o_rsp_hit         (o_rsp_hit),
        .o_rsp_key         (o_rsp_key),
        .o_rsp_volume      (o_rsp_volume),
        .o_rsp_level       (o_rsp_level),
        .o_rsp_last        (o_rsp_last)
    );

    // List state: the first m_cnt entries are valid and sorted.
    key_t    m_keys [N];
    volume_t m_vols [N];
    int      m_cnt = 0;

    always_comb begin
        vld_vec = '0;
        keys_p  = '0;
        vols_p  = '0;
        for (int i = 0; i < N; i++) begin
            vld_vec[i] = (i < m_cnt);
            keys_p[i]  = m_keys[i];
            vols_p[i]  = m_vols[i];
        end
    end
    assign cnt_p = level_t'(m_cnt);

    typedef struct {
        logic    hit;
        key_t    key;
        volume_t vol;
        level_t  lvl;
        logic    last;
    } beat_t;

    beat_t q [$];
    bit    m_dump = 0;
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic void push_exp(input logic [1:0] op,
                                     input key_t k,
                                     input level_t l);
        beat_t b;
        b.hit = 1'b0; b.key = '0; b.vol = '0;
        b.lvl = '0; b.last = 1'b1;
        if (op == 2'd0) begin
            b.key = k;
            for (int i = 0; i < m_cnt; i++) begin
                if (m_keys[i] == k) begin
                    b.hit = 1'b1;
                    b.vol = m_vols[i];
                    b.lvl = level_t'(i);
                end
            end
            q.push_back(b);
        end else if (op == 2'd1) begin
            b.lvl = l;
            if (int'(l) < m_cnt) begin
                b.hit = 1'b1;
                b.key = m_keys[l];
                b.vol = m_vols[l];
            end
            q.push_back(b);
        end else if (op == 2'd2) begin
            if (m_cnt == 0) begin
                q.push_back(b);
            end else begin
                m_dump = 1;
                for (int i = 0; i < m_cnt; i++) begin
                    b.hit  = 1'b1;
                    b.key  = m_keys[i];
                    b.vol  = m_vols[i];
                    b.lvl  = level_t'(i);
                    b.last = (i == m_cnt - 1);
                    q.push_back(b);
                end
            end
        end else begin
            q.push_back(b);
        end
    endfunction

    // Reference model: accept/pop decided from the model's own state.
    initial begin
        bit acc;
        forever begin
            @(posedge clk or posedge arst);
            if (arst) begin
                q.delete();
                m_dump = 0;
            end else begin
                acc = i_qry_vld && !m_dump &&
                      ((q.size() == 0) || i_rsp_rdy);
                if ((q.size() != 0) && i_rsp_rdy) begin
                    if (m_dump && q[0].last) m_dump = 0;
                    void'(q.pop_front());
                end
                if (acc) push_exp(i_qry_op, i_qry_key, i_qry_level);
            end
        end
    end

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("rsp_vld", o_rsp_vld, q.size() != 0);
            chk("qry_rdy", o_qry_rdy,
                !m_dump && ((q.size() == 0) || i_rsp_rdy));
            chk("upd_stall", o_upd_stall, m_dump);
            if (q.size() != 0) begin
                chk("m_hit", o_rsp_hit, q[0].hit);
                chk("m_key", o_rsp_key, q[0].key);
                chk("m_vol", o_rsp_volume, q[0].vol);
                chk("m_lvl", o_rsp_level, q[0].lvl);
                chk("m_last", o_rsp_last, q[0].last);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: sim did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic h,
                       input int k, input int v,
                       input int lv, input logic la);
        chk({nm, ".vld"}, o_rsp_vld, 1);
        chk({nm, ".hit"}, o_rsp_hit, h);
        chk({nm, ".key"}, o_rsp_key, k);
        chk({nm, ".vol"}, o_rsp_volume, v);
        chk({nm, ".lvl"}, o_rsp_level, lv);
        chk({nm, ".last"}, o_rsp_last, la);
    endtask

    // Holds the request until accepted; returns 1ns after the accept edge.
    task automatic issue(input qry_op_t op, input key_t k,
                         input level_t l);
        int  n = 0;
        logic r = 1'b0;
        i_qry_vld   = 1'b1;
        i_qry_op    = op;
        i_qry_key   = k;
        i_qry_level = l;
        while (!r && n < 50) begin
            @(negedge clk);
            r = o_qry_rdy;
            @(posedge clk);
            n++;
        end
        chk("issue_accept", r, 1);
        #1;
        i_qry_vld = 1'b0;
    endtask

    task automatic set_state3();
        for (int i = 0; i < N; i++) begin
            m_keys[i] = 16'd20;
            m_vols[i] = 16'd99;
        end
        m_keys[0] = 16'd10; m_vols[0] = 16'd5;
        m_keys[1] = 16'd20; m_vols[1] = 16'd6;
        m_keys[2] = 16'd30; m_vols[2] = 16'd7;
        m_cnt = 3;
    endtask

    task automatic rand_state();
        int k = 0;
        m_cnt = $urandom_range(0, N);
        for (int i = 0; i < N; i++) begin
            if (i < m_cnt) begin
                k = k + $urandom_range(1, 30);
                m_keys[i] = key_t'(k);
            end else begin
                m_keys[i] = key_t'($urandom_range(0, 200));
            end
            m_vols[i] = volume_t'($urandom);
        end
    endtask

    initial begin
        int r;
        for (int i = 0; i < N; i++) begin
            m_keys[i] = '0;
            m_vols[i] = '0;
        end
        arst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_vld", o_rsp_vld, 0);
        chk("rst_stall", o_upd_stall, 0);
        chk("rst_hit", o_rsp_hit, 0);
        chk("rst_key", o_rsp_key, 0);
        chk("rst_vol", o_rsp_volume, 0);
        chk("rst_lvl", o_rsp_level, 0);
        chk("rst_last", o_rsp_last, 0);
        step();
        arst = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", o_qry_rdy, 1);

        set_state3();
        i_rsp_rdy = 1'b1;
        issue(QRY_KEY, 16'd20, '0);
        @(negedge clk);
        lit("key20", 1, 20, 6, 1, 1);
        issue(QRY_KEY, 16'd25, '0);
        @(negedge clk);
        lit("key25", 0, 25, 0, 0, 1);
        issue(QRY_LEVEL, '0, level_t'(3));
        @(negedge clk);
        lit("lvl3", 0, 0, 0, 3, 1);

        issue(QRY_DUMP, '0, '0);
        @(negedge clk);
        lit("d0", 1, 10, 5, 0, 0);
        chk("d0_stall", o_upd_stall, 1);
        step();
        i_rsp_rdy = 1'b0;
        @(negedge clk);
        lit("d1", 1, 20, 6, 1, 0);
        step();
        i_rsp_rdy = 1'b1;
        @(negedge clk);
        lit("d1_hold", 1, 20, 6, 1, 0);
        chk("d1_stall", o_upd_stall, 1);
        step();
        @(negedge clk);
        lit("d2", 1, 30, 7, 2, 1);
        chk("d2_stall", o_upd_stall, 1);
        step();
        @(negedge clk);
        chk("dump_end_vld", o_rsp_vld, 0);
        chk("dump_end_stall", o_upd_stall, 0);

        m_cnt = 0;
        issue(QRY_DUMP, '0, '0);
        @(negedge clk);
        lit("d_empty", 0, 0, 0, 0, 1);
        chk("d_empty_stall", o_upd_stall, 0);
        step();
        @(negedge clk);
        chk("d_empty_stall2", o_upd_stall, 0);

        set_state3();
        step();
        i_qry_vld = 1'b1;
        i_qry_op = QRY_LEVEL;
        i_qry_level = level_t'(0);
        @(negedge clk);
        step();
        i_qry_level = level_t'(1);
        @(negedge clk);
        lit("b2b0", 1, 10, 5, 0, 1);
        chk("b2b_rdy", o_qry_rdy, 1);
        step();
        i_qry_level = level_t'(2);
        @(negedge clk);
        lit("b2b1", 1, 20, 6, 1, 1);
        step();
        i_qry_vld = 1'b0;
        @(negedge clk);
        lit("b2b2", 1, 30, 7, 2, 1);
        step();

        issue(QRY_DUMP, '0, '0);
        @(negedge clk);
        lit("r0", 1, 10, 5, 0, 0);
        step();
        @(negedge clk);
        lit("r1", 1, 20, 6, 1, 0);
        step();
        @(negedge clk);
        #1;
        arst = 1'b1;
        #1;
        chk("rst_mid_vld", o_rsp_vld, 0);
        chk("rst_mid_stall", o_upd_stall, 0);
        step();
        arst = 1'b0;
        repeat (4) step();
        @(negedge clk);
        chk("rst_mid_nobeat", o_rsp_vld, 0);
        chk("rst_mid_rdy", o_qry_rdy, 1);

        issue(qry_op_t'(2'd3), 16'd10, '0);
        @(negedge clk);
        lit("badop", 0, 0, 0, 0, 1);

        for (int c = 0; c < 3000; c++) begin
            step();
            i_rsp_rdy = ($urandom_range(0, 9) < 7);
            i_qry_vld = ($urandom_range(0, 2) != 0);
            r = $urandom_range(0, 9);
            if (r < 3)      i_qry_op = QRY_KEY;
            else if (r < 6) i_qry_op = QRY_LEVEL;
            else if (r < 8) i_qry_op = QRY_DUMP;
            else            i_qry_op = qry_op_t'(2'd3);
            if ($urandom_range(0, 1) == 0)
                i_qry_key = m_keys[$urandom_range(0, N - 1)];
            else
                i_qry_key = key_t'($urandom_range(0, 200));
            i_qry_level = level_t'($urandom_range(0, N + 2));
            if (!m_dump && ($urandom_range(0, 9) == 0))
                rand_state();
        end
        step();
        i_qry_vld = 1'b0;
        i_rsp_rdy = 1'b1;
        repeat (20) step();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
